// File: rtl/bcd_counter_param.sv
// bcd_counter_param: multi-digit BCD up/down counter with load, snapshot hold and cascade carry.
// Optional macro BCD_COUNTER_SATURATE_EN: saturate at the range limits instead of wrapping.
module bcd_counter_param #(
    parameter int DIGITS         = 6,
    parameter int HOLD_RESET_VAL = 0
) (
    input  logic                F_IN,
    input  logic                RST_N,
    input  logic                ENA,
    input  logic                CLR,
    input  logic                UP,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] D_IN,
    input  logic                LATCH,
    output logic [4*DIGITS-1:0] Q,
    output logic [4*DIGITS-1:0] Q_HOLD,
    output logic                CARRY,
    output logic                CASC
);
    localparam int W = 4*DIGITS;

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] r;
        longint t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i+:4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] HOLD_INIT = to_bcd(longint'(HOLD_RESET_VAL));

    logic [W-1:0] q_cnt, q_ld;
    logic lim, adv, wrap;

    // lim ripples up the digits: a digit steps only while every lower digit sits at its limit
    always_comb begin
        q_cnt = Q;
        q_ld  = D_IN;
        lim   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            q_ld[4*k+:4] = D_IN[4*k+:4] > 4'd9 ? 4'd9 : D_IN[4*k+:4];
            if (lim)
                q_cnt[4*k+:4] = UP ? (Q[4*k+:4] == 4'd9 ? 4'd0 : Q[4*k+:4] + 4'd1)
                                   : (Q[4*k+:4] == 4'd0 ? 4'd9 : Q[4*k+:4] - 4'd1);
            lim = lim & (Q[4*k+:4] == (UP ? 4'd9 : 4'd0));
        end
    end

`ifdef BCD_COUNTER_SATURATE_EN
    logic sat;

    // sat remembers that the limit was already hit, so CARRY pulses only on the first attempt
    always_ff @(posedge F_IN or negedge RST_N)
        if (!RST_N)
            sat <= 1'b0;
        else if (CLR | LOAD)
            sat <= 1'b0;
        else if (ENA)
            sat <= lim;

    assign adv  = ENA & ~lim;
    assign wrap = ENA & lim & ~sat;
    assign CASC = 1'b0;
`else
    assign adv  = ENA;
    assign wrap = ENA & lim;
    assign CASC = ENA & ~CLR & ~LOAD & lim;
`endif

    always_ff @(posedge F_IN or negedge RST_N)
        if (!RST_N) begin
            Q      <= '0;
            Q_HOLD <= HOLD_INIT;
            CARRY  <= 1'b0;
        end else begin
            if (LATCH)
                Q_HOLD <= Q;
            CARRY <= ~CLR & ~LOAD & wrap;
            if (CLR)
                Q <= '0;
            else if (LOAD)
                Q <= q_ld;
            else if (adv)
                Q <= q_cnt;
        end
endmodule

// File: tb/tb_bcd_counter_param.sv
// tb_bcd_counter_param: directed vector table plus reset sequences for bcd_counter_param.
module tb_bcd_counter_param;
`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        f_in, rst_n, ena, clr, up, load, latch;
    logic [23:0] d_in, q, q_hold;
    logic        carry, casc;
    int          n_chk, n_fail;

    bcd_counter_param #(.DIGITS(6), .HOLD_RESET_VAL(0)) dut (
        .F_IN(f_in), .RST_N(rst_n), .ENA(ena), .CLR(clr), .UP(up), .LOAD(load),
        .D_IN(d_in), .LATCH(latch), .Q(q), .Q_HOLD(q_hold), .CARRY(carry), .CASC(casc)
    );

    typedef struct {
        logic        clr, load, ena, up, latch;
        logic [23:0] d, q, hold;
        logic        carry, casc;
    } vec_t;

    vec_t v[$];

    initial begin
        f_in = 1'b0;
        forever #5 f_in = ~f_in;
    end

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge_wait;
        @(posedge f_in);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0; ena = 0; clr = 0; up = 1; load = 0; latch = 0; d_in = '0;
        repeat (3) begin
            edge_wait;
            chk("rst_q", q, 24'h0);
            chk("rst_hold", q_hold, 24'h0);
            chk("rst_carry", {23'b0, carry}, 24'h0);
        end
        rst_n = 1'b1;

        //          clr load ena up latch d            q            hold         carry casc
        v.push_back('{0, 0, 0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 0});
        v.push_back('{0, 0, 0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 0});
        v.push_back('{0, 1, 0, 1, 0, 24'h000998, 24'h000998, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 1, 0, 24'h000000, 24'h000999, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 1, 0, 24'h000000, 24'h001000, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 1, 0, 24'h000000, 24'h001001, 24'h000000, 0, 0});
        v.push_back('{0, 1, 1, 1, 0, 24'h999999, 24'h999999, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 1, 0, 24'h000000, SAT ? 24'h999999 : 24'h000000, 24'h000000, 1, !SAT});
        v.push_back('{0, 0, 1, 1, 0, 24'h000000, SAT ? 24'h999999 : 24'h000001, 24'h000000, 0, 0});
        v.push_back('{0, 1, 1, 0, 0, 24'h000000, 24'h000000, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 0, 0, 24'h000000, SAT ? 24'h000000 : 24'h999999, 24'h000000, 1, !SAT});
        v.push_back('{0, 0, 1, 0, 0, 24'h000000, SAT ? 24'h000000 : 24'h999998, 24'h000000, 0, 0});
        v.push_back('{0, 0, 0, 0, 0, 24'h000000, SAT ? 24'h000000 : 24'h999998, 24'h000000, 0, 0});
        v.push_back('{0, 1, 0, 1, 0, 24'h00A0F5, 24'h009095, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 1, 0, 24'h000000, 24'h009096, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 0, 0, 24'h000000, 24'h009095, 24'h000000, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 24'h001000, 24'h001000, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 0, 0, 24'h000000, 24'h000999, 24'h000000, 0, 0});
        v.push_back('{0, 1, 0, 1, 0, 24'h000122, 24'h000122, 24'h000000, 0, 0});
        v.push_back('{0, 0, 1, 1, 0, 24'h000000, 24'h000123, 24'h000000, 0, 0});
        v.push_back('{1, 0, 1, 1, 1, 24'h000000, 24'h000000, 24'h000123, 0, 0});
        v.push_back('{0, 0, 1, 1, 1, 24'h000000, 24'h000001, 24'h000000, 0, 0});
        v.push_back('{1, 1, 0, 1, 0, 24'h555555, 24'h000000, 24'h000000, 0, 0});
        v.push_back('{0, 1, 0, 1, 0, 24'h999999, 24'h999999, 24'h000000, 0, 0});
        v.push_back('{0, 0, 0, 1, 0, 24'h000000, 24'h999999, 24'h000000, 0, 0});
        v.push_back('{1, 0, 1, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 0});

        foreach (v[i]) begin
            clr = v[i].clr; load = v[i].load; ena = v[i].ena; up = v[i].up;
            latch = v[i].latch; d_in = v[i].d;
            #1;
            chk($sformatf("v%0d_casc", i), {23'b0, casc}, {23'b0, v[i].casc});
            edge_wait;
            chk($sformatf("v%0d_q", i), q, v[i].q);
            chk($sformatf("v%0d_hold", i), q_hold, v[i].hold);
            chk($sformatf("v%0d_carry", i), {23'b0, carry}, {23'b0, v[i].carry});
        end

        // snapshot a nonzero value, then reset asynchronously between edges
        clr = 0; load = 1; ena = 0; up = 1; latch = 0; d_in = 24'h000456;
        edge_wait;
        load = 0; ena = 1; latch = 1;
        edge_wait;
        chk("pre_rst_q", q, 24'h000457);
        chk("pre_rst_hold", q_hold, 24'h000456);
        latch = 0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_q", q, 24'h0);
        chk("async_hold", q_hold, 24'h0);
        chk("async_carry", {23'b0, carry}, 24'h0);
        edge_wait;
        chk("held_rst_q", q, 24'h0);
        rst_n = 1'b1;
        edge_wait;
        chk("post_rst_q", q, 24'h000001);
        ena = 0;
        edge_wait;
        chk("post_rst_hold", q, 24'h000001);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_counter_param.md
Name: bcd_counter_param

Overview:
Parametrised multi-digit synchronous BCD counter. It is the next-generation decimal counter for the measurement/display path. Each 4-bit digit is kept in BCD directly through a per-digit carry/borrow cascade, with no binary-to-BCD divide. Adds up/down mode, parallel load, a snapshot hold register for gated frequency measurement, and a registered carry/borrow output that lets several blocks be chained.

Parameters:
DIGITS, 6, number of BCD digits; the count range is 0 to 10^DIGITS-1.
HOLD_RESET_VAL, 0, decimal value driven on Q_HOLD after reset; must be below 10^DIGITS.

Ports:
F_IN  input  1  counting clock; all state updates on its rising edge.
RST_N  input  1  asynchronous active-low reset.
ENA  input  1  count enable.
CLR  input  1  synchronous clear; highest synchronous priority.
UP  input  1  direction: 1 = up, 0 = down.
LOAD  input  1  synchronous parallel load.
D_IN  input  4*DIGITS  BCD load value; digit 0 is in [3:0].
LATCH  input  1  snapshot strobe for Q_HOLD.
Q  output  4*DIGITS  live BCD count; digit k is in [4k+3:4k].
Q_HOLD  output  4*DIGITS  last snapshot of Q.
CARRY  output  1  registered one-cycle wrap pulse (up or down).
CASC  output  1  combinational cascade enable; drives the next block's ENA.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - Q = 0.
  - Q_HOLD = HOLD_RESET_VAL in BCD.
  - CARRY = 0.
  - Reset takes effect immediately, including mid-count. The first edge after release obeys the normal priorities.
- Synchronous priority: CLR > LOAD > ENA count > hold.
  - CLR: Q <= 0 and CARRY <= 0.
  - LOAD: each digit <= D_IN nibble. Any nibble above 9 is clamped to 9. CARRY <= 0.
  - ENA=1, UP=1:
    - Digit k increments when all digits below k are 9.
    - A digit at 9 that increments becomes 0.
    - All-9s goes to all-0s and CARRY <= 1 for exactly one cycle.
  - ENA=1, UP=0:
    - Digit k decrements when all digits below k are 0.
    - A digit at 0 that decrements becomes 9.
    - All-0s goes to all-9s and CARRY <= 1 for one cycle.
  - ENA=0 with no CLR or LOAD: Q holds and CARRY <= 0.
- CASC = ENA & ~CLR & ~LOAD & (UP ? Q is all 9s : Q is all 0s). It is combinational and asserts in the cycle before the wrap, so a chained block advances on the same edge.
- LATCH:
  - On the edge where LATCH=1, Q_HOLD <= Q as it was before that edge's update.
  - LATCH is independent of CLR, LOAD and ENA.
  - LATCH together with CLR captures the pre-clear value. This is the gate-close/clear sequence used for frequency metering.
- Latency: Q, Q_HOLD and CARRY update one edge after their inputs are sampled. There is no pipelining.
- Q never holds a non-BCD digit, under any input sequence.
- Changing UP while counting takes effect on the next edge, with no extra delay.

Optional Feature:
Macro: BCD_COUNTER_SATURATE_EN
- Defined:
  - Up count at all-9s holds at all-9s; down count at all-0s holds at 0.
  - CARRY pulses once on the first attempt beyond the limit, then stays 0 while the count is held there.
  - CASC is forced to 0.
- Undefined: wrap-around behaviour as specified above.

Test Plan:
- Reset with RST_N=0 for 3 cycles, then release with ENA=0 → Q=0x000000, Q_HOLD=0x000000, CARRY=0, and all three stay there.
- LOAD with D_IN=0x000998, then ENA=1, UP=1 for 3 edges → Q goes 0x000999, 0x001000, 0x001001; CARRY stays 0.
- LOAD 0x999999, ENA=1, UP=1, 1 edge → Q=0x000000 and CARRY=1 for one cycle. CASC=1 in the cycle before that edge. With the macro defined, Q stays 0x999999, CARRY still pulses once, then stays 0.
- LOAD 0x000000, ENA=1, UP=0, 2 edges → Q goes 0x999999 then 0x999998; CARRY pulses on the first edge only.
- LOAD with D_IN=0x00A0F5 → Q=0x009095, because invalid nibbles are clamped to 9.
- Count to 0x000123, then assert LATCH and CLR on the same edge → Q_HOLD=0x000123 and Q=0x000000. Assert RST_N=0 mid-count → Q goes to 0 immediately, without waiting for an F_IN edge.
